fp_issue_arb: RTL and testbench

- Shares one fp_top instance among NUM_REQ requesters, e.g. an integer pipe and a vector/LSU sideband.
- Round-robin arbitration; one operation in flight at a time.
- Registers the winner's operands and drives the FPU start pulse.
- Waits for FPU valid, then returns result and flags to the owning requester through a valid/ready response handshake.

---
 rtl/fp_issue_arb_pkg.sv | 73 +++++++
 rtl/fp_issue_arb_rr_pick.sv | 37 +++
 rtl/fp_issue_arb.sv | 187 ++++++++++++++++++
 tb/tb_fp_issue_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_issue_arb_pkg.sv
// Shared types for the FPU issue arbiter: formats, opcodes, rounding modes,
// status flags, arbiter states and per-format helper functions.
package fp_issue_arb_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2,
    BF16 = 2'd3
  } fp_format_e;

  localparam int unsigned FpMaxWidth = 64;

  typedef enum logic [3:0] {
    FADD   = 4'd0,
    FSUB   = 4'd1,
    FMUL   = 4'd2,
    FMADD  = 4'd3,
    FNMSUB = 4'd4,
    FDIV   = 4'd5,
    FSQRT  = 4'd6,
    FMIN   = 4'd7,
    FMAX   = 4'd8,
    FCMP   = 4'd9,
    F2I    = 4'd10,
    I2F    = 4'd11,
    F2F    = 4'd12
  } float_op_e;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    DYN = 3'd7
  } roundmode_e;

  typedef struct packed {
    logic NV;  // invalid
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Storage width of one operand for the given format.
  function automatic int unsigned fp_width(fp_format_e fmt);
    unique case (fmt)
      FP64:       return 64;
      FP16, BF16: return 16;
      default:    return 32;
    endcase
  endfunction

  // Canonical quiet NaN, right-aligned in a FpMaxWidth container.
  function automatic logic [FpMaxWidth-1:0] canon_nan(fp_format_e fmt);
    unique case (fmt)
      FP64:    return 64'h7FF8_0000_0000_0000;
      FP16:    return 64'h0000_0000_0000_7E00;
      BF16:    return 64'h0000_0000_0000_7FC0;
      default: return 64'h0000_0000_7FC0_0000;
    endcase
  endfunction

endpackage

// File: rtl/fp_issue_arb_rr_pick.sv
// fp_rr_pick: combinational round-robin picker. Scans upward from the slot
// after last_i, wrapping, and returns the first set request.
module fp_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  // Two passes: slots above last_i first, then the wrapped slots 0..last_i.
  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req_i[j] && (j > 32'(last_i))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req_i[j] && (j <= 32'(last_i))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/fp_issue_arb.sv
// fp_issue_arb: shares one FPU among NUM_REQ requesters, one op in flight.
// Round-robin accept, registered operands, single-cycle start pulse, then a
// valid/ready response to the owning requester.
// Optional build macro FP_ARB_WATCHDOG_EN adds a WAIT-state timeout that
// answers with a canonical qNaN + NV and sets sticky wdog_err_o.
module fp_issue_arb
  import fp_issue_arb_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT = FP32,
  parameter int unsigned NUM_REQ   = 2,
`ifdef FP_ARB_WATCHDOG_EN
  parameter int unsigned WDOG_CYCLES = 64,
`endif
  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT),
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic       [NUM_REQ-1:0]           req_valid_i,
  output logic       [NUM_REQ-1:0]           req_ready_o,
  input  logic       [NUM_REQ-1:0][FP_WIDTH-1:0] req_a_i,
  input  logic       [NUM_REQ-1:0][FP_WIDTH-1:0] req_b_i,
  input  logic       [NUM_REQ-1:0][FP_WIDTH-1:0] req_c_i,
  input  float_op_e  [NUM_REQ-1:0]           req_op_i,
  input  logic       [NUM_REQ-1:0][1:0]      req_op_modify_i,
  input  roundmode_e [NUM_REQ-1:0]           req_rnd_i,
  output logic       [NUM_REQ-1:0]           rsp_valid_o,
  input  logic       [NUM_REQ-1:0]           rsp_ready_i,
  output logic       [FP_WIDTH-1:0]          rsp_result_o,
  output status_t                            rsp_flags_o,
  output logic                               fpu_start_o,
  input  logic                               fpu_ready_i,
  output logic       [FP_WIDTH-1:0]          fpu_a_o,
  output logic       [FP_WIDTH-1:0]          fpu_b_o,
  output logic       [FP_WIDTH-1:0]          fpu_c_o,
  output float_op_e                          fpu_op_o,
  output logic       [1:0]                   fpu_op_modify_o,
  output roundmode_e                         fpu_rnd_o,
  input  logic       [FP_WIDTH-1:0]          fpu_result_i,
  input  logic                               fpu_valid_i,
  input  status_t                            fpu_flags_i,
`ifdef FP_ARB_WATCHDOG_EN
  output logic                               wdog_err_o,
`endif
  output logic                               busy_o
);

  // Operand width follows FP_FORMAT, so the capture struct lives here.
  typedef struct packed {
    logic [FP_WIDTH-1:0] a;
    logic [FP_WIDTH-1:0] b;
    logic [FP_WIDTH-1:0] c;
    float_op_e           op;
    logic [1:0]          op_modify;
    roundmode_e          rnd;
  } req_t;

  arb_state_e          state_q;
  logic [ID_W-1:0]     owner_q;
  logic [ID_W-1:0]     last_q;
  req_t                req_q;
  req_t                win_req;
  logic [FP_WIDTH-1:0] res_q;
  status_t             flags_q;
  logic                zl_q;  // result already captured in the start cycle

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  owner_oh;

`ifdef FP_ARB_WATCHDOG_EN
  localparam int unsigned     WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [FP_WIDTH-1:0] QNAN = FP_WIDTH'(canon_nan(FP_FORMAT));
  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_err_q;
`endif

  fp_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign win_req = '{
    a:         req_a_i[pick_idx],
    b:         req_b_i[pick_idx],
    c:         req_c_i[pick_idx],
    op:        req_op_i[pick_idx],
    op_modify: req_op_modify_i[pick_idx],
    rnd:       req_rnd_i[pick_idx]
  };

  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  // Accept is offered only in IDLE and never while reset is being applied.
  assign req_ready_o = ((state_q == StIdle) && !rst_i) ? pick_gnt : '0;
  assign rsp_valid_o = (state_q == StResp) ? owner_oh : '0;
  assign fpu_start_o = (state_q == StIssue) && fpu_ready_i;
  assign busy_o      = (state_q != StIdle);

  assign fpu_a_o         = req_q.a;
  assign fpu_b_o         = req_q.b;
  assign fpu_c_o         = req_q.c;
  assign fpu_op_o        = req_q.op;
  assign fpu_op_modify_o = req_q.op_modify;
  assign fpu_rnd_o       = req_q.rnd;
  assign rsp_result_o    = res_q;
  assign rsp_flags_o     = flags_q;
`ifdef FP_ARB_WATCHDOG_EN
  assign wdog_err_o      = wdog_err_q;
`endif

  // Arbiter FSM with all operand, owner and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
      req_q      <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      zl_q       <= 1'b0;
`ifdef FP_ARB_WATCHDOG_EN
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            req_q   <= win_req;
            owner_q <= pick_idx;
            last_q  <= pick_idx;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (fpu_ready_i) begin
            state_q <= StWait;
            // A zero-latency result is latched now and retired from WAIT next
            // cycle, exactly as if it had arrived in WAIT.
            zl_q    <= fpu_valid_i;
            if (fpu_valid_i) begin
              res_q   <= fpu_result_i;
              flags_q <= fpu_flags_i;
            end
`ifdef FP_ARB_WATCHDOG_EN
            wdog_cnt_q <= '0;
`endif
          end
        end
        StWait: begin
          if (zl_q || fpu_valid_i) begin
            if (!zl_q) begin
              res_q   <= fpu_result_i;
              flags_q <= fpu_flags_i;
            end
            zl_q    <= 1'b0;
            state_q <= StResp;
          end
`ifdef FP_ARB_WATCHDOG_EN
          else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
            res_q      <= QNAN;
            flags_q    <= '{NV: 1'b1, default: 1'b0};
            wdog_err_q <= 1'b1;
            state_q    <= StResp;
          end else begin
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          if (rsp_ready_i[owner_q]) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_issue_arb.sv
// Self-checking bench for fp_issue_arb with a mock FPU and a response
// scoreboard. Define FP_ARB_WATCHDOG_EN to also exercise the timeout path.
module tb_fp_issue_arb;
  import fp_issue_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       [1:0]       req_valid = '0;
  logic       [1:0]       req_ready;
  logic       [1:0][31:0] ra = '0, rb = '0, rc = '0;
  float_op_e  [1:0]       rop = '{FADD, FADD};
  logic       [1:0][1:0]  rmod = '0;
  roundmode_e [1:0]       rrnd = '{RNE, RNE};
  logic       [1:0]       rsp_valid;
  logic       [1:0]       rsp_ready = 2'b11;
  logic       [31:0]      rsp_result;
  status_t                rsp_flags;
  logic                   fpu_start;
  logic                   fpu_ready = 1'b1;
  logic       [31:0]      fpu_a, fpu_b, fpu_c;
  float_op_e              fpu_op;
  logic       [1:0]       fpu_mod;
  roundmode_e             fpu_rnd;
  logic       [31:0]      fpu_result = '0;
  logic                   fpu_valid = 1'b0;
  status_t                fpu_flags = '0;
  logic                   busy;
`ifdef FP_ARB_WATCHDOG_EN
  logic                   wdog_err;
`endif

  fp_issue_arb #(
    .FP_FORMAT   (FP32),
`ifdef FP_ARB_WATCHDOG_EN
    .WDOG_CYCLES (8),
`endif
    .NUM_REQ     (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_a_i         (ra),
    .req_b_i         (rb),
    .req_c_i         (rc),
    .req_op_i        (rop),
    .req_op_modify_i (rmod),
    .req_rnd_i       (rrnd),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .rsp_flags_o     (rsp_flags),
    .fpu_start_o     (fpu_start),
    .fpu_ready_i     (fpu_ready),
    .fpu_a_o         (fpu_a),
    .fpu_b_o         (fpu_b),
    .fpu_c_o         (fpu_c),
    .fpu_op_o        (fpu_op),
    .fpu_op_modify_o (fpu_mod),
    .fpu_rnd_o       (fpu_rnd),
    .fpu_result_i    (fpu_result),
    .fpu_valid_i     (fpu_valid),
    .fpu_flags_i     (fpu_flags),
`ifdef FP_ARB_WATCHDOG_EN
    .wdog_err_o      (wdog_err),
`endif
    .busy_o          (busy)
  );

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  exp_t exp_q[$];
  int   glog[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   issued[2] = '{0, 0};
  int   done[2] = '{0, 0};
  int   lat = 2;
  bit   fpu_mute = 1'b0;
  bit   stray_pend = 1'b0;
  int   fpu_cnt = 0;
  int   n_start = 0, n_rsp = 0;
  int   acc_cyc = -1, start_cyc = -1;
  logic [31:0] m_res = '0;
  logic [4:0]  m_fl = '0;

  // Mock FPU arithmetic: one real FADD point, otherwise a routing-sensitive hash.
  function automatic logic [31:0] mock_res(float_op_e op, logic [1:0] md, roundmode_e rm,
                                           logic [31:0] a, logic [31:0] b, logic [31:0] c);
    if (op == FADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ (c << 1) ^ {23'd0, op, rm, md};
  endfunction

  function automatic logic [4:0] mock_fl(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    return a[4:0] ^ b[4:0] ^ c[4:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_ops(input int i);
    ra[i]   = $urandom;
    rb[i]   = $urandom;
    rc[i]   = $urandom;
    rop[i]  = float_op_e'(4'($urandom_range(0, 12)));
    rmod[i] = 2'($urandom_range(0, 3));
    rrnd[i] = roundmode_e'(3'($urandom_range(0, 4)));
  endtask

  task automatic issue(input int i, input int n);
    issued[i] += n;
    req_valid[i] = issued[i] > done[i];
  endtask

  // One clock: monitor at negedge, then drive requesters and mock FPU at posedge+1.
  task automatic tick();
    logic [1:0] acc;
    logic       st;
    exp_t       e;
    @(negedge clk);
    cyc++;
    acc = rst ? 2'b00 : (req_valid & req_ready);
    st  = fpu_start;
    if (!rst) begin
      check("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      check("rsp_valid_onehot0", 64'($onehot0(rsp_valid)), 64'd1);
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        e.id = i;
        if (fpu_mute) begin
          e.res = 32'h7FC0_0000;
          e.fl  = 5'b10000;
        end else begin
          e.res = mock_res(rop[i], rmod[i], rrnd[i], ra[i], rb[i], rc[i]);
          e.fl  = mock_fl(ra[i], rb[i], rc[i]);
        end
        exp_q.push_back(e);
        glog.push_back(i);
        acc_cyc = cyc;
      end
    end
    if (st) begin
      n_start++;
      start_cyc = cyc;
      m_res = mock_res(fpu_op, fpu_mod, fpu_rnd, fpu_a, fpu_b, fpu_c);
      m_fl  = mock_fl(fpu_a, fpu_b, fpu_c);
    end
    if (!rst && (rsp_valid & rsp_ready) != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_owner", 64'(rsp_valid), 64'(2'b01 << e.id));
        check("rsp_result", 64'(rsp_result), 64'(e.res));
        check("rsp_flags", 64'(rsp_flags), 64'(e.fl));
        n_rsp++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        done[i]++;
        new_ops(i);
      end
      req_valid[i] = issued[i] > done[i];
    end
    fpu_valid  = 1'b0;
    fpu_result = $urandom;
    fpu_flags  = status_t'(5'($urandom));
    if (st && !fpu_mute) fpu_cnt = lat;
    if (fpu_cnt > 0) begin
      fpu_cnt--;
      if (fpu_cnt == 0) begin
        fpu_valid  = 1'b1;
        fpu_result = m_res;
        fpu_flags  = status_t'(m_fl);
      end
    end
    if (stray_pend) begin
      fpu_valid  = 1'b1;
      stray_pend = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((issued[0] != done[0] || issued[1] != done[1] || exp_q.size() != 0 || busy)
           && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_drain"}, 64'(k < 200), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0, a0, k;
    logic [31:0] snap_res;
    logic [4:0]  snap_fl;
    int          glen;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_fpu_start", 64'(fpu_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fpu_a", 64'(fpu_a), 64'd0);
    check("rst_fpu_op", 64'(fpu_op), 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_rsp_flags", 64'(rsp_flags), 64'd0);
`ifdef FP_ARB_WATCHDOG_EN
    check("rst_wdog_err", 64'(wdog_err), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Single FADD request from requester 0
    ra[0] = 32'h3F80_0000; rb[0] = 32'h4000_0000; rc[0] = '0;
    rop[0] = FADD; rmod[0] = 2'd0; rrnd[0] = RNE;
    glog.delete();
    issue(0, 1);
    wait_idle("single");
    check("single_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
    check("single_start_lat", 64'(start_cyc - acc_cyc), 64'd1);
    check("single_nstart", 64'(n_start), 64'd1);
    check("single_nrsp", 64'(n_rsp), 64'd1);

    // Contention: both requesters continuously pending
    glog.delete();
    issue(0, 4);
    issue(1, 4);
    wait_idle("contend");
    check("contend_count", 64'(glog.size()), 64'd8);
    for (int i = 0; i < glog.size(); i++) begin
      check($sformatf("contend_grant%0d", i), 64'(glog[i]), 64'((i % 2 == 0) ? 1 : 0));
    end

    // FPU backpressure while in ISSUE
    fpu_ready = 1'b0;
    s0 = n_start;
    a0 = acc_cyc;
    issue(0, 1);
    k = 0;
    while (acc_cyc == a0 && k < 20) begin
      tick();
      k++;
    end
    check("fbp_accept", 64'(k < 20), 64'd1);
    repeat (5) tick();
    check("fbp_no_start", 64'(n_start), 64'(s0));
    check("fbp_busy", 64'(busy), 64'd1);
    fpu_ready = 1'b1;
    tick();
    check("fbp_start_now", 64'(n_start), 64'(s0 + 1));
    wait_idle("fbp");
    check("fbp_single_pulse", 64'(n_start), 64'(s0 + 1));

    // Response backpressure plus a stray rsp_ready from the non-owner
    rsp_ready = 2'b10;
    issue(0, 1);
    k = 0;
    while (rsp_valid == 2'b00 && k < 30) begin
      tick();
      k++;
    end
    check("rbp_reach_resp", 64'(k < 30), 64'd1);
    snap_res = rsp_result;
    snap_fl  = rsp_flags;
    glen = glog.size();
    issue(1, 1);
    repeat (4) begin
      tick();
      check("rbp_valid_hold", 64'(rsp_valid), 64'd1);
      check("rbp_result_hold", 64'(rsp_result), 64'(snap_res));
      check("rbp_flags_hold", 64'(rsp_flags), 64'(snap_fl));
      check("rbp_no_ready", 64'(req_ready), 64'd0);
    end
    check("rbp_no_accept", 64'(glog.size()), 64'(glen));
    rsp_ready = 2'b11;
    wait_idle("rbp");
    check("rbp_next_grant", 64'(glog[glog.size()-1]), 64'd1);

    // Stray fpu_valid while idle
    s0 = n_start;
    stray_pend = 1'b1;
    repeat (3) tick();
    check("stray_busy", 64'(busy), 64'd0);
    check("stray_rsp", 64'(rsp_valid), 64'd0);
    check("stray_start", 64'(n_start), 64'(s0));

    // Reset while in WAIT; the late FPU result must be dropped
    lat = 6;
    a0 = start_cyc;
    issue(0, 1);
    k = 0;
    while (start_cyc == a0 && k < 20) begin
      tick();
      k++;
    end
    check("rwait_started", 64'(k < 20), 64'd1);
    check("rwait_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rwait_busy_clr", 64'(busy), 64'd0);
    repeat (8) begin
      tick();
      check("rwait_no_rsp", 64'(rsp_valid), 64'd0);
      check("rwait_idle", 64'(busy), 64'd0);
    end
    lat = 2;
    glog.delete();
    issue(0, 1);
    issue(1, 1);
    wait_idle("rwait_both");
    check("rwait_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
    check("rwait_second", 64'(glog.size() > 1 ? glog[1] : -1), 64'd1);
    glog.delete();
    issue(1, 1);
    wait_idle("rwait_solo1");
    check("rwait_solo1_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd1);

`ifdef FP_ARB_WATCHDOG_EN
    // Watchdog: FPU never answers
    check("wdog_clear_before", 64'(wdog_err), 64'd0);
    fpu_mute = 1'b1;
    issue(0, 1);
    wait_idle("wdog");
    fpu_mute = 1'b0;
    check("wdog_err_set", 64'(wdog_err), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
